// File: rtl/alpha_blend_pkg.sv
// alpha_blend_pkg: shared FSM encoding and pixel channel constants for the blender front end
package alpha_blend_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_STREAM} state_e;
  localparam int CH_W = 8;
  localparam int ALPHA_MSB = 31;
  localparam int ALPHA_LSB = 24;
endpackage

// File: rtl/alpha_blend_sync_fifo.sv
// alpha_blend_sync_fifo: synchronous FIFO with flush and a registered not-full ready
module alpha_blend_sync_fifo #(
  parameter int W = 33,
  parameter int D = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         en_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         ready_o
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic ready_q, full, push_ok, pop_ok;
  assign full = cnt_q == (AW+1)'(D);
  assign empty_o = cnt_q == '0;
  assign data_o = mem_q[rd_q];
  assign ready_o = ready_q;
  always_comb begin
    push_ok = push_i && !full && !flush_i;
    pop_ok = pop_i && !empty_o && !flush_i;
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q <= flush_i ? '0 : wr_q + AW'(push_ok);
      rd_q <= flush_i ? '0 : rd_q + AW'(pop_ok);
      cnt_q <= cnt_d;
      ready_q <= en_i && cnt_d != (AW+1)'(D);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/alpha_blend_pixel_sync.sv
// alpha_blend_pixel_sync: aligns foreground/background streams on SOF and emits windowed blend pairs
module alpha_blend_pixel_sync
  import alpha_blend_pkg::*;
#(
  parameter int g_V1_DATAWIDTH = 4*CH_W,
  parameter int g_V2_DATAWIDTH = 3*CH_W,
  parameter int g_FIFO_DEPTH = 8,
  parameter int g_CNT_WIDTH = 12
) (
  input  logic                      SYS_CLK_I,
  input  logic                      RESET_I,
  input  logic                      ENABLE_i,
  input  logic                      BLEND_EN_i,
  input  logic [g_CNT_WIDTH-1:0]    HRES_i,
  input  logic [g_CNT_WIDTH-1:0]    VRES_i,
  input  logic [g_CNT_WIDTH-1:0]    WIN_X0_i,
  input  logic [g_CNT_WIDTH-1:0]    WIN_X1_i,
  input  logic [g_CNT_WIDTH-1:0]    WIN_Y0_i,
  input  logic [g_CNT_WIDTH-1:0]    WIN_Y1_i,
  input  logic [g_V1_DATAWIDTH-1:0] V1_DATA_i,
  input  logic                      V1_SOF_i,
  input  logic                      V1_VALID_i,
  output logic                      V1_READY_o,
  input  logic [g_V2_DATAWIDTH-1:0] V2_DATA_i,
  input  logic                      V2_SOF_i,
  input  logic                      V2_VALID_i,
  output logic                      V2_READY_o,
  output logic [g_V1_DATAWIDTH-1:0] V1_RDATA_o,
  output logic [g_V2_DATAWIDTH-1:0] V2_RDATA_o,
  output logic                      Valid_o,
  output logic                      Start_Alpha_blend_o,
  output logic                      Frame_done_o,
  output logic                      Sync_err_o
);
  state_e state_q, state_d;
  logic [g_CNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [g_V1_DATAWIDTH:0] h1;
  logic [g_V2_DATAWIDTH:0] h2;
  logic [g_V1_DATAWIDTH-1:0] v1_q;
  logic [g_V2_DATAWIDTH-1:0] v2_q;
  logic e1, e2, sof1, sof2, pop1, pop2, pair, err_d, done_d, last_x, last_y, in_win;
  logic valid_q, start_q, done_q, err_q;
  alpha_blend_sync_fifo #(.W(g_V1_DATAWIDTH+1), .D(g_FIFO_DEPTH)) u_fifo_v1 (
    .clk_i(SYS_CLK_I), .rst_i(RESET_I), .flush_i(state_q == ST_IDLE), .en_i(state_d != ST_IDLE),
    .push_i(V1_VALID_i && V1_READY_o), .pop_i(pop1), .data_i({V1_SOF_i, V1_DATA_i}),
    .data_o(h1), .empty_o(e1), .ready_o(V1_READY_o)
  );
  alpha_blend_sync_fifo #(.W(g_V2_DATAWIDTH+1), .D(g_FIFO_DEPTH)) u_fifo_v2 (
    .clk_i(SYS_CLK_I), .rst_i(RESET_I), .flush_i(state_q == ST_IDLE), .en_i(state_d != ST_IDLE),
    .push_i(V2_VALID_i && V2_READY_o), .pop_i(pop2), .data_i({V2_SOF_i, V2_DATA_i}),
    .data_o(h2), .empty_o(e2), .ready_o(V2_READY_o)
  );
  assign sof1 = h1[g_V1_DATAWIDTH];
  assign sof2 = h2[g_V2_DATAWIDTH];
  assign last_x = x_q == HRES_i - g_CNT_WIDTH'(1);
  assign last_y = y_q == VRES_i - g_CNT_WIDTH'(1);
  assign in_win = BLEND_EN_i && x_q >= WIN_X0_i && x_q <= WIN_X1_i && y_q >= WIN_Y0_i && y_q <= WIN_Y1_i;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    pop1 = 1'b0;
    pop2 = 1'b0;
    pair = 1'b0;
    err_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_ALIGN;
      ST_ALIGN: begin
        pop1 = !e1 && !sof1;
        pop2 = !e2 && !sof2;
        x_d = '0;
        y_d = '0;
        if (!e1 && !e2 && sof1 && sof2) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // an SOF off the frame origin is left at the head so ALIGN can restart on it
        if (((!e1 && sof1) || (!e2 && sof2)) && (x_q != '0 || y_q != '0)) begin
          err_d = 1'b1;
          state_d = ST_ALIGN;
        end else if (!e1 && !e2) begin
          pair = 1'b1;
          pop1 = 1'b1;
          pop2 = 1'b1;
          x_d = last_x ? '0 : x_q + g_CNT_WIDTH'(1);
          y_d = !last_x ? y_q : last_y ? '0 : y_q + g_CNT_WIDTH'(1);
          done_d = last_x && last_y;
          state_d = (last_x && last_y) ? ST_ALIGN : ST_STREAM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!ENABLE_i) begin
      state_d = ST_IDLE;
      pop1 = 1'b0;
      pop2 = 1'b0;
      pair = 1'b0;
      err_d = 1'b0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge SYS_CLK_I) begin
    if (RESET_I) begin
      state_q <= ST_IDLE;
      x_q <= '0;
      y_q <= '0;
      valid_q <= 1'b0;
      v1_q <= '0;
      v2_q <= '0;
      start_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      valid_q <= pair;
      v1_q <= pair ? h1[g_V1_DATAWIDTH-1:0] : '0;
      v2_q <= pair ? h2[g_V2_DATAWIDTH-1:0] : '0;
      start_q <= pair && in_win;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign Valid_o = valid_q;
  assign V1_RDATA_o = v1_q;
  assign V2_RDATA_o = v2_q;
  assign Start_Alpha_blend_o = start_q;
  assign Frame_done_o = done_q;
  assign Sync_err_o = err_q;
endmodule

// File: tb/tb_alpha_blend_pixel_sync.sv
// tb_alpha_blend_pixel_sync: directed frames with a queue scoreboard checked by a decoupled monitor
module tb_alpha_blend_pixel_sync;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, blend = 1'b0;
  logic [11:0] hres, vres, x0, x1, y0, y1;
  logic [31:0] v1d, r1;
  logic [23:0] v2d, r2;
  logic v1s, v1v, v1r, v2s, v2v, v2r, valid, start, done, err;
  typedef struct packed {logic [31:0] d1; logic [23:0] d2; logic st; logic dn;} exp_t;
  exp_t exp_q[$];
  logic [32:0] q1[$];
  logic [24:0] q2[$];
  int checks = 0, failures = 0, err_cnt = 0;
  bit gap2 = 1'b0, t5 = 1'b0, full_seen = 1'b0;
  always #5 clk = ~clk;
  alpha_blend_pixel_sync dut (
    .SYS_CLK_I(clk), .RESET_I(rst), .ENABLE_i(en), .BLEND_EN_i(blend),
    .HRES_i(hres), .VRES_i(vres), .WIN_X0_i(x0), .WIN_X1_i(x1), .WIN_Y0_i(y0), .WIN_Y1_i(y1),
    .V1_DATA_i(v1d), .V1_SOF_i(v1s), .V1_VALID_i(v1v), .V1_READY_o(v1r),
    .V2_DATA_i(v2d), .V2_SOF_i(v2s), .V2_VALID_i(v2v), .V2_READY_o(v2r),
    .V1_RDATA_o(r1), .V2_RDATA_o(r2), .Valid_o(valid), .Start_Alpha_blend_o(start),
    .Frame_done_o(done), .Sync_err_o(err)
  );
  function automatic logic [31:0] p1(input int t, input int i);
    return {8'hC0, 8'(t), 8'(i), 8'h5A};
  endfunction
  function automatic logic [23:0] p2(input int t, input int i);
    return {8'(t), 8'(i), 8'hA5};
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  task automatic frame1(input int t, input int n);
    for (int i = 0; i < n; i++) q1.push_back({i == 0, p1(t, i)});
  endtask
  task automatic frame2(input int t, input int n);
    for (int i = 0; i < n; i++) q2.push_back({i == 0, p2(t, i)});
  endtask
  task automatic expect_pair(input int t1, input int t2, input int i, input bit st, input bit dn);
    exp_q.push_back({p1(t1, i), p2(t2, i), st, dn});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      tick(1);
      n++;
    end
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick(3);
  endtask
  initial begin
    logic a1;
    v1v = 1'b0; v1s = 1'b0; v1d = '0;
    forever begin
      @(negedge clk);
      a1 = v1v && v1r;
      @(posedge clk);
      #1;
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      v1v = q1.size() > 0;
      {v1s, v1d} = q1.size() > 0 ? q1[0] : 33'd0;
    end
  end
  initial begin
    logic a2;
    bit tog;
    tog = 1'b0;
    v2v = 1'b0; v2s = 1'b0; v2d = '0;
    forever begin
      @(negedge clk);
      a2 = v2v && v2r;
      @(posedge clk);
      #1;
      if (a2 && q2.size() > 0) void'(q2.pop_front());
      tog = ~tog;
      v2v = q2.size() > 0 && (!gap2 || tog);
      {v2s, v2d} = q2.size() > 0 ? q2[0] : 25'd0;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (err) err_cnt++;
      if (t5 && !v1r) full_seen = 1'b1;
      if (valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 64'(valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("v1_rdata", 64'(r1), 64'(e.d1));
          chk("v2_rdata", 64'(r2), 64'(e.d2));
          chk("start_blend", 64'(start), 64'(e.st));
          chk("frame_done", 64'(done), 64'(e.dn));
        end
      end else chk("zero_when_invalid", 64'({r1, r2, start, done}), 64'd0);
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    hres = 4; vres = 2; x0 = 1; x1 = 2; y0 = 0; y1 = 0; blend = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    frame1(0, 2);
    frame2(0, 2);
    tick(6);
    chk("idle_v1_ready", 64'(v1r), 64'd0);
    chk("idle_v2_ready", 64'(v2r), 64'd0);
    chk("idle_outputs", 64'({valid, start, done, err}), 64'd0);
    chk("idle_no_pop_v1", 64'(q1.size()), 64'd2);
    chk("idle_no_pop_v2", 64'(q2.size()), 64'd2);
    q1.delete();
    q2.delete();
    tick(2);
    frame1(1, 8);
    frame2(1, 8);
    for (int i = 0; i < 8; i++) expect_pair(1, 1, i, i == 1 || i == 2, i == 7);
    en = 1'b1;
    drain("aligned");
    chk("aligned_sync_err", 64'(err_cnt), 64'd0);
    for (int k = 0; k < 3; k++) q1.push_back({1'b0, p1(8'hEE, k)});
    frame1(2, 8);
    frame2(2, 8);
    for (int i = 0; i < 8; i++) expect_pair(2, 2, i, i == 1 || i == 2, i == 7);
    drain("misaligned");
    chk("misaligned_sync_err", 64'(err_cnt), 64'd0);
    frame1(3, 8);
    frame1(4, 8);
    frame2(3, 2);
    frame2(5, 8);
    expect_pair(3, 3, 0, 1'b0, 1'b0);
    expect_pair(3, 3, 1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) expect_pair(4, 5, i, i == 1 || i == 2, i == 7);
    drain("mid_sof");
    chk("mid_sof_sync_err", 64'(err_cnt), 64'd1);
    hres = 8; vres = 4; x0 = 2; x1 = 5; y0 = 1; y1 = 2;
    gap2 = 1'b1;
    t5 = 1'b1;
    frame1(6, 32);
    frame2(6, 32);
    for (int i = 0; i < 32; i++)
      expect_pair(6, 6, i, (i % 8) >= 2 && (i % 8) <= 5 && (i / 8) >= 1 && (i / 8) <= 2, i == 31);
    drain("backpressure");
    t5 = 1'b0;
    gap2 = 1'b0;
    chk("v1_ready_deasserted", 64'(full_seen), 64'd1);
    chk("backpressure_sync_err", 64'(err_cnt), 64'd1);
    hres = 4; vres = 2; x0 = 1; x1 = 2; y0 = 0; y1 = 0;
    frame1(7, 8);
    frame2(7, 8);
    for (int i = 0; i < 3; i++) expect_pair(7, 7, i, i == 1 || i == 2, 1'b0);
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      tick(1);
      if (valid) n++;
    end
    chk("enable_drop_reached_px3", 64'(n), 64'd3);
    en = 1'b0;
    tick(5);
    chk("enable_drop_pending", 64'(exp_q.size()), 64'd0);
    q1.delete();
    q2.delete();
    tick(2);
    for (int k = 0; k < 2; k++) q1.push_back({1'b0, p1(8'hEE, k)});
    frame1(8, 8);
    frame2(8, 8);
    for (int i = 0; i < 8; i++) expect_pair(8, 8, i, i == 1 || i == 2, i == 7);
    en = 1'b1;
    drain("reenable");
    hres = 2; vres = 1; x0 = 3; x1 = 1; y0 = 0; y1 = 0;
    frame1(9, 2);
    frame2(9, 2);
    for (int i = 0; i < 2; i++) expect_pair(9, 9, i, 1'b0, i == 1);
    drain("empty_window");
    chk("final_sync_err", 64'(err_cnt), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
